// File: rtl/fht_result_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fht_result_reader_if
//  Description : Read-side bundle between fht_top's result banks, the result
//                reader and the downstream valid/ready consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fht_result_reader_if #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
);
    logic                    iFHT_RDY;
    logic [A_BIT-1:0]        oADDR_RD;
    logic signed [D_BIT-1:0] iDATA_0;
    logic signed [D_BIT-1:0] iDATA_1;
    logic signed [D_BIT-1:0] iDATA_2;
    logic signed [D_BIT-1:0] iDATA_3;
    logic signed [D_BIT-1:0] oDATA;
    logic [A_BIT+1:0]        oINDEX;
    logic                    oVALID;
    logic                    iREADY;
    logic                    oBUSY;
    logic                    oDONE;

    // Reader side
    modport master (
        input  iFHT_RDY, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        output oADDR_RD, oDATA, oINDEX, oVALID, oBUSY, oDONE
    );

    // RAM / consumer side
    modport slave (
        output iFHT_RDY, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        input  oADDR_RD, oDATA, oINDEX, oVALID, oBUSY, oDONE
    );
endinterface
`default_nettype wire

// File: rtl/fht_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fht_result_reader
//  Description : Unloads the four fht_top result banks after oRDY rises and
//                streams the 4*2^A_BIT results in natural bin order over a
//                valid/ready port, absorbing RAM read latency in a skid FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module fht_result_reader #(
    parameter int D_BIT      = 16,
    parameter int A_BIT      = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           iCLK,
    input  wire logic           iRESET,
    fht_result_reader_if.master bus
);

    localparam int c_nw = A_BIT + 2;
    localparam int c_cw = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam int c_pw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_rdy_d;
    logic [c_nw-1:0]         r_n;

    // Read-return pipeline: valid, bank select and bin index ride alongside the RAM read
    logic                    r_vpipe     [RD_LAT];
    logic [1:0]              r_bank_pipe [RD_LAT];
    logic [c_nw-1:0]         r_idx_pipe  [RD_LAT];

    logic signed [D_BIT-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_nw-1:0]         r_fifo_idx  [FIFO_DEPTH];
    logic [c_pw-1:0]         r_wr_ptr;
    logic [c_pw-1:0]         r_rd_ptr;
    logic [c_cw-1:0]         r_count;

    logic [c_cw-1:0]         w_in_flight;
    logic                    w_trigger;
    logic                    w_issue;
    logic                    w_last_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_valid;
    logic signed [D_BIT-1:0] w_ret_data;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        if (p == c_pw'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + c_pw'(1);
    endfunction

    // Count reads issued but not yet written into the FIFO
    always_comb begin
        w_in_flight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_in_flight = w_in_flight + c_cw'(r_vpipe[k]);
        end
    end

    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & bus.iREADY;
    assign w_push       = r_vpipe[RD_LAT-1];
    assign w_trigger    = bus.iFHT_RDY & ~r_rdy_d & (r_state == S_IDLE);
    // Issue only when every outstanding read is guaranteed a FIFO slot
    assign w_issue      = (r_state == S_READ) &&
                          ((r_count + w_in_flight) < c_cw'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_n == '1);

    // Pick the bank whose data is returning this cycle
    always_comb begin
        w_ret_data = bus.iDATA_0;
        case (r_bank_pipe[RD_LAT-1])
            2'd0:    w_ret_data = bus.iDATA_0;
            2'd1:    w_ret_data = bus.iDATA_1;
            2'd2:    w_ret_data = bus.iDATA_2;
            default: w_ret_data = bus.iDATA_3;
        endcase
    end

    // State register and oRDY edge detector
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state <= S_IDLE;
            r_rdy_d <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_rdy_d <= bus.iFHT_RDY;
        end
    end

    // Next-state logic; DRAIN ends in the cycle the final word leaves so oDONE follows it directly
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_state_next = S_READ;
            S_READ:  if (w_last_issue) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if ((w_in_flight == '0) &&
                    ((r_count == '0) || ((r_count == c_cw'(1)) && w_pop))) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Issue counter {q, a}; wraps to 0 after the final address
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_n <= '0;
        end else if (w_issue) begin
            r_n <= r_n + c_nw'(1);
        end
    end

    // Tag pipeline matching the RAM read latency
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vpipe[k]     <= 1'b0;
                r_bank_pipe[k] <= '0;
                r_idx_pipe[k]  <= '0;
            end
        end else begin
            r_vpipe[0]     <= w_issue;
            r_bank_pipe[0] <= {r_n[A_BIT], r_n[A_BIT+1]};
            r_idx_pipe[0]  <= r_n;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vpipe[k]     <= r_vpipe[k-1];
                r_bank_pipe[k] <= r_bank_pipe[k-1];
                r_idx_pipe[k]  <= r_idx_pipe[k-1];
            end
        end
    end

    // Skid FIFO; storage is cleared on reset so the head reads as zero
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo_data[k] <= '0;
                r_fifo_idx[k]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_ret_data;
                r_fifo_idx[r_wr_ptr]  <= r_idx_pipe[RD_LAT-1];
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.oADDR_RD = r_n[A_BIT-1:0];
    assign bus.oDATA    = r_fifo_data[r_rd_ptr];
    assign bus.oINDEX   = r_fifo_idx[r_rd_ptr];
    assign bus.oVALID   = w_valid;
    assign bus.oBUSY    = (r_state != S_IDLE);
    assign bus.oDONE    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fht_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fht_result_reader
//  Description : Self-checking bench for fht_result_reader with a 2-cycle
//                registered bank model preloaded with 1000*bank + addr.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fht_result_reader;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] a_q;

    fht_result_reader_if #(.D_BIT(16), .A_BIT(4)) bus ();

    fht_result_reader #(
        .D_BIT(16), .A_BIT(4), .RD_LAT(2), .FIFO_DEPTH(4)
    ) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Result banks: registered address and registered data (2-cycle latency)
    always @(posedge clk) begin
        a_q         <= bus.oADDR_RD;
        bus.iDATA_0 <= 16'd0    + {12'd0, a_q};
        bus.iDATA_1 <= 16'd1000 + {12'd0, a_q};
        bus.iDATA_2 <= 16'd2000 + {12'd0, a_q};
        bus.iDATA_3 <= 16'd3000 + {12'd0, a_q};
    end

    typedef struct {
        int idx;
        int exp;
    } vec_t;

    int         n_checks = 0;
    int         n_bad    = 0;
    int         cyc      = 0;
    int         rmode    = 0;
    int         trig_cyc = 0;
    int         first_valid_cyc;
    int         last_xfer_cyc;
    int         done_cyc;
    int         done_cnt;
    int         n_rx;
    logic [15:0] got_data [64];
    logic [5:0]  got_idx  [64];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [5:0]  prev_idx;
    vec_t        tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_data(input int i);
        int q, a, bank;
        q    = i / 16;
        a    = i % 16;
        bank = (q % 2) * 2 + (q / 2);
        return 1000 * bank + a;
    endfunction

    // One clock cycle: drive iREADY, sample outputs mid-cycle, record transfers
    task automatic step();
        @(negedge clk);
        cyc++;
        case (rmode)
            0:       bus.iREADY = 1'b1;
            1:       bus.iREADY = 1'($urandom_range(0, 1));
            default: bus.iREADY = (cyc > trig_cyc + 20);
        endcase
        if (prev_stall) begin
            chk("hold_valid", 64'(bus.oVALID), 64'd1);
            chk("hold_data",  64'(bus.oDATA),  64'(prev_data));
            chk("hold_index", 64'(bus.oINDEX), 64'(prev_idx));
        end
        prev_stall = bus.oVALID && !bus.iREADY && !rst;
        prev_data  = bus.oDATA;
        prev_idx   = bus.oINDEX;
        if (bus.oVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.oVALID && bus.iREADY) begin
            if (n_rx < 64) begin
                got_data[n_rx] = bus.oDATA;
                got_idx[n_rx]  = bus.oINDEX;
            end
            n_rx++;
            last_xfer_cyc = cyc;
        end
        if (bus.oDONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rmode == 1) chk("occupancy_le_4", 64'(dut.r_count <= 3'd4), 64'd1);
    endtask

    task automatic run_readout(input int mode, input int reedge_at, input int reset_at);
        int  budget;
        bit  reedged;
        rmode           = mode;
        bus.iFHT_RDY    = 1'b0;
        step();
        step();
        n_rx            = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        prev_stall      = 1'b0;
        reedged         = 1'b0;
        bus.iFHT_RDY    = 1'b1;
        trig_cyc        = cyc;
        budget          = 0;
        while (budget < 2000) begin
            step();
            budget++;
            if (mode == 2 && cyc == trig_cyc + 10) chk("t3_addr_frozen_early", 64'(bus.oADDR_RD), 64'd4);
            if (mode == 2 && cyc == trig_cyc + 20) begin
                chk("t3_addr_frozen", 64'(bus.oADDR_RD), 64'd4);
                chk("t3_head_valid",  64'(bus.oVALID),   64'd1);
                chk("t3_head_index",  64'(bus.oINDEX),   64'd0);
            end
            if (reedged) bus.iFHT_RDY = 1'b1;
            if (reedge_at >= 0 && !reedged && n_rx == reedge_at) begin
                bus.iFHT_RDY = 1'b0;
                reedged      = 1'b1;
            end
            if (reset_at >= 0 && n_rx == reset_at) begin
                rst        = 1'b1;
                prev_stall = 1'b0;
                step();
                chk("rst_valid", 64'(bus.oVALID),   64'd0);
                chk("rst_busy",  64'(bus.oBUSY),    64'd0);
                chk("rst_done",  64'(bus.oDONE),    64'd0);
                chk("rst_data",  64'(bus.oDATA),    64'd0);
                chk("rst_index", 64'(bus.oINDEX),   64'd0);
                chk("rst_addr",  64'(bus.oADDR_RD), 64'd0);
                rst = 1'b0;
                for (int i = 0; i < 6; i++) step();
                chk("rst_no_more_busy",  64'(bus.oBUSY),    64'd0);
                chk("rst_no_more_valid", 64'(bus.oVALID),   64'd0);
                chk("rst_addr_idle",     64'(bus.oADDR_RD), 64'd0);
                chk("rst_no_done",       64'(done_cnt),     64'd0);
                return;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 5) break;
        end
        bus.iFHT_RDY = 1'b0;
        chk("readout_completed", 64'(done_cnt > 0), 64'd1);
        chk("word_count",  64'(n_rx),     64'd64);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("done_after_last", 64'(done_cyc), 64'(last_xfer_cyc + 1));
        for (int i = 0; i < 64 && i < n_rx; i++) begin
            chk("stream_index", 64'(got_idx[i]),  64'(i));
            chk("stream_data",  64'(got_data[i]), 64'(exp_data(i)));
        end
        if (mode == 0) chk("first_valid_latency", 64'(first_valid_cyc - trig_cyc), 64'd4);
    endtask

    initial begin
        tbl[0] = '{idx: 0,  exp: 0};
        tbl[1] = '{idx: 5,  exp: 5};
        tbl[2] = '{idx: 15, exp: 15};
        tbl[3] = '{idx: 16, exp: 2000};
        tbl[4] = '{idx: 17, exp: 2001};
        tbl[5] = '{idx: 32, exp: 1000};
        tbl[6] = '{idx: 40, exp: 1008};
        tbl[7] = '{idx: 48, exp: 3000};
        tbl[8] = '{idx: 63, exp: 3015};

        rst          = 1'b1;
        bus.iFHT_RDY = 1'b0;
        bus.iREADY   = 1'b0;
        n_rx         = 0;
        done_cnt     = 0;
        first_valid_cyc = -1;
        repeat (3) step();
        chk("reset_addr",  64'(bus.oADDR_RD), 64'd0);
        chk("reset_data",  64'(bus.oDATA),    64'd0);
        chk("reset_index", 64'(bus.oINDEX),   64'd0);
        chk("reset_valid", 64'(bus.oVALID),   64'd0);
        chk("reset_busy",  64'(bus.oBUSY),    64'd0);
        chk("reset_done",  64'(bus.oDONE),    64'd0);
        rst = 1'b0;
        repeat (2) step();
        chk("idle_busy", 64'(bus.oBUSY), 64'd0);

        // T1: full-rate readout plus spot values from the table
        run_readout(0, -1, -1);
        for (int i = 0; i < 9; i++) begin
            chk("table_data", 64'(got_data[tbl[i].idx]), 64'(tbl[i].exp));
        end
        chk("wrap_addr", 64'(bus.oADDR_RD), 64'd0);

        // T2: random backpressure
        run_readout(1, -1, -1);

        // T3: consumer stalled for 20 cycles after the trigger
        run_readout(2, -1, -1);

        // T4: oRDY already high as reset releases
        rst          = 1'b1;
        bus.iFHT_RDY = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_no_start", 64'(bus.oBUSY), 64'd0);
        end
        run_readout(0, -1, -1);

        // T5: reset at word 30, then a fresh full readout
        run_readout(0, -1, 30);
        run_readout(0, -1, -1);

        // T6: second rising edge mid-readout is ignored
        run_readout(0, 10, -1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
